seven_segment_scanner: RTL

Time-multiplexed driver for a DIGITS-wide common-anode/cathode seven-segment display. It scans one digit per refresh slot and decodes hex nibbles to segments. Extras: leading-zero blanking, per-digit decimal points, anti-ghosting blank time, and frame-synchronous (tear-free) value update. It sits between the processor's debug/IO register and the board display pins.

---
 rtl/seg_pkg.sv | 47 ++++
 rtl/hex_seg_decode.sv | 14 +
 rtl/seven_segment_scanner.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Seven-segment glyph table shared by the scanner and its decoder.
// Segment vectors are ordered {a,b,c,d,e,f,g} and are active-high; pin
// polarity is applied later in the scanner's output stage.
package seg_pkg;

  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_A   = 7'b1110111;
  localparam logic [6:0] SEG_B   = 7'b0011111;
  localparam logic [6:0] SEG_C   = 7'b1001110;
  localparam logic [6:0] SEG_D   = 7'b0111101;
  localparam logic [6:0] SEG_E   = 7'b1001111;
  localparam logic [6:0] SEG_F   = 7'b1000111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0:    glyph = SEG_0;
      4'h1:    glyph = SEG_1;
      4'h2:    glyph = SEG_2;
      4'h3:    glyph = SEG_3;
      4'h4:    glyph = SEG_4;
      4'h5:    glyph = SEG_5;
      4'h6:    glyph = SEG_6;
      4'h7:    glyph = SEG_7;
      4'h8:    glyph = SEG_8;
      4'h9:    glyph = SEG_9;
      4'hA:    glyph = SEG_A;
      4'hB:    glyph = SEG_B;
      4'hC:    glyph = SEG_C;
      4'hD:    glyph = SEG_D;
      4'hE:    glyph = SEG_E;
      default: glyph = SEG_F;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble : 4-bit hex digit
//   seg    : {a,b,c,d,e,f,g}, active-high (1 = segment lit)
module hex_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment display driver.
// One digit is selected per refresh slot; each slot opens with BLANK_CYCLES
// of all-anodes-off to suppress ghosting. Displayed data lives in a shadow
// register that only changes at frame boundaries (or continuously while the
// display is disabled), so a frame never mixes old and new digits.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   enable     : 0 = dark display, scan counters held at 0
//   value      : DIGITS hex nibbles, nibble 0 is the rightmost digit
//   dp_mask    : per-digit decimal point request
//   load       : capture value/dp_mask into the staging register
//   blank_lz   : suppress leading zero digits (digit 0 always shown)
//   seg, dp    : segments {a..g} and decimal point, pin polarity
//   an         : one-hot digit select, pin polarity
//   frame_done : one-cycle pulse at the first cycle of each new frame
module seven_segment_scanner #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  import seg_pkg::*;

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] BLANK_TH = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  localparam logic [6:0]        SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_IDLE  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_IDLE  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                                 : {DIGITS{1'b0}};

  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] staging_value;
  logic [DIGITS-1:0]   staging_dp;
  logic [4*DIGITS-1:0] shadow_value;
  logic [DIGITS-1:0]   shadow_dp;
  logic                pending;

  logic                frame_end;
  logic                commit_point;
  logic                update;

  // Stage p0: slot selection, digit mux, decode and polarity from (pre, idx, shadow)
  logic                slot_active_p0;
  logic [3:0]          nibble_p0;
  logic                dp_bit_p0;
  logic [DIGITS-1:0]   an_onehot_p0;
  logic                lz_blank_p0;
  logic                upper_zero_p0;
  logic [6:0]          seg_decoded_p0;
  logic [6:0]          seg_ah_p0;
  logic                dp_ah_p0;
  logic [DIGITS-1:0]   an_ah_p0;
  logic [6:0]          seg_pin_p0;
  logic                dp_pin_p0;
  logic [DIGITS-1:0]   an_pin_p0;

  assign frame_end    = (idx == IDX_LAST) && (pre == PRE_LAST);
  // While disabled the shadow tracks updates immediately; otherwise only at frame end.
  assign commit_point = !enable || frame_end;
  assign update       = load || pending;

  assign slot_active_p0 = enable && (pre >= BLANK_TH);

  // Walk from the most significant digit down, so upper_zero_p0 at digit i
  // means nibbles i..DIGITS-1 are all zero.
  always_comb begin
    nibble_p0     = 4'h0;
    dp_bit_p0     = 1'b0;
    an_onehot_p0  = '0;
    lz_blank_p0   = 1'b0;
    upper_zero_p0 = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero_p0 = upper_zero_p0 && (shadow_value[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        nibble_p0       = shadow_value[4*i +: 4];
        dp_bit_p0       = shadow_dp[i];
        an_onehot_p0[i] = 1'b1;
        lz_blank_p0     = upper_zero_p0 && (i != 0);
      end
    end
  end

  hex_seg_decode u_decode (
    .nibble (nibble_p0),
    .seg    (seg_decoded_p0)
  );

  // A blanked leading zero keeps its anode and decimal point so slot timing
  // and brightness stay uniform across digits.
  assign seg_ah_p0 = (slot_active_p0 && !(blank_lz && lz_blank_p0)) ? seg_decoded_p0 : SEG_OFF;
  assign dp_ah_p0  = slot_active_p0 && dp_bit_p0;
  assign an_ah_p0  = slot_active_p0 ? an_onehot_p0 : '0;

  assign seg_pin_p0 = (SEG_ACTIVE_LOW != 0) ? ~seg_ah_p0 : seg_ah_p0;
  assign dp_pin_p0  = (SEG_ACTIVE_LOW != 0) ? ~dp_ah_p0  : dp_ah_p0;
  assign an_pin_p0  = (AN_ACTIVE_LOW  != 0) ? ~an_ah_p0  : an_ah_p0;

  // Stage p1: registered pins, scan counters and value staging
  always_ff @(posedge clk) begin
    if (rst) begin
      pre           <= '0;
      idx           <= '0;
      staging_value <= '0;
      staging_dp    <= '0;
      shadow_value  <= '0;
      shadow_dp     <= '0;
      pending       <= 1'b0;
      seg           <= SEG_IDLE;
      dp            <= DP_IDLE;
      an            <= AN_IDLE;
      frame_done    <= 1'b0;
    end else begin
      seg        <= seg_pin_p0;
      dp         <= dp_pin_p0;
      an         <= an_pin_p0;
      frame_done <= enable && frame_end;

      if (!enable) begin
        pre <= '0;
        idx <= '0;
      end else if (pre == PRE_LAST) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end

      if (load) begin
        staging_value <= value;
        staging_dp    <= dp_mask;
        pending       <= 1'b1;
      end

      // A load arriving on the commit cycle bypasses staging and lands directly.
      if (commit_point) begin
        pending <= 1'b0;
        if (update) begin
          shadow_value <= load ? value   : staging_value;
          shadow_dp    <= load ? dp_mask : staging_dp;
        end
      end
    end
  end

endmodule
